// File: rtl/load_store_unit.sv
// Load/store unit: turns a single core memory request into word-indexed
// accesses on a simple data memory. Handles byte/half/word loads with sign
// or zero extension, and stores. Partial stores use a read-modify-write.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] A,
  output logic [31:0] WD,
  output logic        WE,
  input  logic [31:0] RD
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WRITE,
    DONE
  } state_t;

  state_t      state;
  logic        op_store;
  logic [1:0]  lane_q;
  logic [2:0]  funct3_q;
  logic [15:0] wdata_q;

  logic        req_valid;
  logic        req_err;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic [31:0] merged;

  // Qualify the incoming request and flag illegal widths or misalignment
  always_comb begin
    req_valid = start & (mem_read ^ mem_write);
    req_err   = 1'b0;
    if (mem_read) begin
      case (funct3)
        3'b000, 3'b100: req_err = 1'b0;
        3'b001, 3'b101: req_err = addr[0];
        3'b010:         req_err = |addr[1:0];
        default:        req_err = 1'b1;
      endcase
    end else begin
      case (funct3)
        3'b000:  req_err = 1'b0;
        3'b001:  req_err = addr[0];
        3'b010:  req_err = |addr[1:0];
        default: req_err = 1'b1;
      endcase
    end
  end

  // Bring the addressed lane down to bit 0 and extend it to a full word
  always_comb begin
    shifted  = RD >> {lane_q, 3'b000};
    load_val = shifted;
    case (funct3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_val = {24'h000000, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_val = {16'h0000, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  // Overlay the store byte or half onto the current memory word
  always_comb begin
    merged = RD;
    if (funct3_q[1:0] == 2'b00) begin
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  // Request sequencer with all memory-side and status outputs registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      op_store <= 1'b0;
      lane_q   <= 2'b00;
      funct3_q <= 3'b000;
      wdata_q  <= 16'h0000;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rdata    <= 32'h0;
      A        <= 32'h0;
      WD       <= 32'h0;
      WE       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_store <= mem_write;
            lane_q   <= addr[1:0];
            funct3_q <= funct3;
            wdata_q  <= wdata[15:0];
            busy     <= 1'b1;
            err      <= req_err;
            if (req_err) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              A     <= {2'b00, addr[31:2]};
              state <= ACCESS;
              if (mem_write && (funct3 == 3'b010)) begin
                WE <= 1'b1;
                WD <= wdata;
              end
            end
          end
        end
        ACCESS: begin
          if (op_store && (funct3_q != 3'b010)) begin
            WE    <= 1'b1;
            WD    <= merged;
            state <= WRITE;
          end else begin
            if (!op_store) begin
              rdata <= load_val;
            end
            A     <= 32'h0;
            WE    <= 1'b0;
            WD    <= 32'h0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        WRITE: begin
          A     <= 32'h0;
          WE    <= 1'b0;
          WD    <= 32'h0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
